// File: rtl/qkd_ctrl_pkg.sv
// Shared types and field widths for the QKD read controller slice.
package qkd_ctrl_pkg;

  localparam int VAL_W   = 8;
  localparam int BASIS_W = 2;
  localparam int PHASE_W = 2;
  localparam int ID_W    = 4;
  localparam int TIME_W  = 8;

  typedef enum logic [2:0] {
    S_UNPROV = 3'd0,
    S_PROV   = 3'd1,
    S_ARMED  = 3'd2,
    S_READ   = 3'd3,
    S_RESP   = 3'd4,
    S_SPENT  = 3'd5,
    S_FUSED  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK     = 2'd0,
    STAT_DENIED = 2'd1,
    STAT_SPENT  = 2'd2,
    STAT_FUSED  = 2'd3
  } status_t;

endpackage

// File: rtl/qkd_rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping.
module qkd_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int PW = $clog2(NUM_REQ);

  always_comb begin
    logic [PW-1:0] cand;
    cand  = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = PW'((32'(ptr) + off) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qkd_read_arbiter.sv
// One-shot read controller/arbiter for a symbolic_qkd_register cell.
// Optional identity pre-filter in ARMED: define QKD_ARB_ID_FILTER_EN.
module qkd_read_arbiter
  import qkd_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 1
`ifdef QKD_ARB_ID_FILTER_EN
  ,
  parameter logic [3:0] ALLOWED_ID = 4'hA
`endif
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       prov_req,
  input  logic                       fuse_req,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [BASIS_W*NUM_REQ-1:0] req_basis,
  input  logic [PHASE_W*NUM_REQ-1:0] req_phase,
  input  logic [ID_W*NUM_REQ-1:0]    req_identity,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [1:0]                 resp_status,
  output logic [VAL_W-1:0]           resp_data,
  output logic                       reg_init,
  output logic                       reg_read,
  output logic [BASIS_W-1:0]         reg_basis,
  output logic [PHASE_W-1:0]         reg_phase,
  output logic [ID_W-1:0]            reg_identity,
  output logic [TIME_W-1:0]          reg_time,
  output logic                       reg_fuse_blow,
  input  logic [VAL_W-1:0]           reg_value,
  input  logic                       reg_oe,
  input  logic                       reg_fuse_fire,
  output logic [2:0]                 state_out,
  output logic                       tamper_flag
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t             state, state_nx;
  status_t            status_q;
  logic [VAL_W-1:0]   data_q;
  logic [NUM_REQ-1:0] resp_valid_q, pend, grant;
  logic [PW-1:0]      ptr_q, g_q, gidx, ptr_nx;
  logic               any, fuse_blow_q, read_d, tamper_q;
  logic               anomaly, reject, resp_fix;
  logic [TIME_W-1:0]  time_q;
  logic [DW-1:0]      div_q;

  // The requester being answered this cycle still holds req; mask it out.
  assign pend = req & ~resp_valid_q;

  qkd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (pend),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign ptr_nx = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

`ifdef QKD_ARB_ID_FILTER_EN
  assign reject = (req_identity[gidx*ID_W +: ID_W] != ALLOWED_ID);
`else
  assign reject = 1'b0;
`endif

  // Fire must appear exactly one cycle after READ; oe only during READ.
  assign anomaly = (state != S_FUSED) &&
                   ((reg_fuse_fire != read_d) || (reg_oe && (state != S_READ)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q  <= '0;
      time_q <= '0;
    end else if (div_q == DW'(TICK_DIV - 1)) begin
      div_q <= '0;
      if (time_q != '1) time_q <= time_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_UNPROV;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if ((state != S_FUSED) && (fuse_req || anomaly)) begin
      state_nx = S_FUSED;
    end else begin
      case (state)
        S_UNPROV: if (prov_req) state_nx = S_PROV;
        S_PROV:   state_nx = S_ARMED;
        S_ARMED:  if (any) state_nx = reject ? S_ARMED : S_READ;
        S_READ:   state_nx = S_RESP;
        S_RESP:   state_nx = S_SPENT;
        default:  state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      g_q          <= '0;
      resp_valid_q <= '0;
      status_q     <= STAT_OK;
      data_q       <= '0;
      fuse_blow_q  <= 1'b0;
      read_d       <= 1'b0;
      tamper_q     <= 1'b0;
    end else begin
      fuse_blow_q  <= fuse_req && (state != S_FUSED);
      read_d       <= (state == S_READ);
      if (anomaly) tamper_q <= 1'b1;
      resp_valid_q <= '0;
      status_q     <= STAT_OK;
      data_q       <= '0;
      case (state)
        S_ARMED: begin
          if (any && (state_nx != S_FUSED)) begin
            ptr_q <= ptr_nx;
            g_q   <= gidx;
            if (reject) begin
              resp_valid_q <= grant;
              status_q     <= STAT_DENIED;
            end
          end
        end
        S_READ: begin
          resp_valid_q[g_q] <= 1'b1;
          if (state_nx == S_FUSED) begin
            status_q <= STAT_FUSED;
          end else if (reg_oe) begin
            status_q <= STAT_OK;
            data_q   <= reg_value;
          end else begin
            status_q <= STAT_DENIED;
          end
        end
        S_SPENT, S_FUSED: begin
          if (any) begin
            ptr_q        <= ptr_nx;
            resp_valid_q <= grant;
            status_q     <= (state_nx == S_FUSED) ? STAT_FUSED : STAT_SPENT;
          end
        end
        default: ;
      endcase
    end
  end

  // A response already registered in RESP is downgraded if the cell misbehaves now.
  always_comb begin
    reg_init     = (state == S_PROV);
    reg_read     = (state == S_READ);
    reg_basis    = '0;
    reg_phase    = '0;
    reg_identity = '0;
    if (state == S_READ) begin
      reg_basis    = req_basis[g_q*BASIS_W +: BASIS_W];
      reg_phase    = req_phase[g_q*PHASE_W +: PHASE_W];
      reg_identity = req_identity[g_q*ID_W +: ID_W];
    end
    resp_fix    = (state == S_RESP) && (fuse_req || anomaly);
    resp_valid  = resp_valid_q;
    resp_status = resp_fix ? STAT_FUSED : status_q;
    resp_data   = resp_fix ? '0 : data_q;
  end

  assign reg_time      = time_q;
  assign reg_fuse_blow = fuse_blow_q;
  assign state_out     = state;
  assign tamper_flag   = tamper_q;

endmodule

// File: tb/tb_qkd_read_arbiter.sv
// Directed bench for qkd_read_arbiter with a behavioural stand-in for the cell.
module tb_qkd_read_arbiter;
  localparam int N = 4;
  localparam logic [7:0] CELL_VAL = 8'h5C;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0, prov_req = 1'b0, fuse_req = 1'b0;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] req_basis = '0, req_phase = '0;
  logic [4*N-1:0] req_identity = '0;
  logic [N-1:0]   resp_valid;
  logic [1:0]     resp_status;
  logic [7:0]     resp_data;
  logic           reg_init, reg_read, reg_fuse_blow;
  logic [1:0]     reg_basis, reg_phase;
  logic [3:0]     reg_identity;
  logic [7:0]     reg_time, reg_value;
  logic           reg_oe, reg_fuse_fire;
  logic [2:0]     state_out;
  logic           tamper_flag;

  int total = 0, bad = 0;

  qkd_read_arbiter #(.NUM_REQ(N), .TICK_DIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .prov_req(prov_req), .fuse_req(fuse_req),
    .req(req), .req_basis(req_basis), .req_phase(req_phase), .req_identity(req_identity),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_data(resp_data),
    .reg_init(reg_init), .reg_read(reg_read), .reg_basis(reg_basis), .reg_phase(reg_phase),
    .reg_identity(reg_identity), .reg_time(reg_time), .reg_fuse_blow(reg_fuse_blow),
    .reg_value(reg_value), .reg_oe(reg_oe), .reg_fuse_fire(reg_fuse_fire),
    .state_out(state_out), .tamper_flag(tamper_flag)
  );

  always #5 clk = ~clk;

  // Cell stand-in: tags basis=01 phase=10 id=A, window 10..200, dies on any read.
  logic cell_armed = 1'b0, cell_dead = 1'b0, fire_q = 1'b0, force_fire = 1'b0, cell_oe;
  always @(posedge clk) begin
    if (!reset_n) begin
      cell_armed <= 1'b0;
      cell_dead  <= 1'b0;
      fire_q     <= 1'b0;
    end else begin
      if (reg_init) cell_armed <= 1'b1;
      if (reg_read) cell_dead <= 1'b1;
      fire_q <= reg_read;
    end
  end
  assign cell_oe = reg_read && cell_armed && !cell_dead && reg_basis == 2'b01 &&
                   reg_phase == 2'b10 && reg_identity == 4'hA &&
                   reg_time >= 8'd10 && reg_time <= 8'd200;
  assign reg_value     = cell_oe ? CELL_VAL : 8'h00;
  assign reg_oe        = cell_oe;
  assign reg_fuse_fire = fire_q | force_fire;

  int cyc = 0, n_init = 0, n_read = 0, n_blow = 0;
  logic [1:0] rd_basis = '0;
  logic [3:0] rd_id = '0;
  logic [7:0] rd_time = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (reg_init) n_init <= n_init + 1;
    if (reg_fuse_blow) n_blow <= n_blow + 1;
    if (reg_read) begin
      n_read   <= n_read + 1;
      rd_basis <= reg_basis;
      rd_id    <= reg_identity;
      rd_time  <= reg_time;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_meta(input int i, input logic [1:0] b, input logic [1:0] p, input logic [3:0] id);
    req_basis[i*2 +: 2]    = b;
    req_phase[i*2 +: 2]    = p;
    req_identity[i*4 +: 4] = id;
  endtask

  task automatic provision();
    prov_req = 1'b1;
    tick(1);
    prov_req = 1'b0;
  endtask

  task automatic wait_time(input int t);
    for (int i = 0; i < 300 && int'(reg_time) < t; i++) tick(1);
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int i = 0; i < 50 && state_out != s; i++) tick(1);
  endtask

  // Waits for a response, then drops that requester's req after the response cycle.
  task automatic wait_resp(input int budget, output logic [N-1:0] v, output logic [1:0] st,
                           output logic [7:0] d, output int at);
    v = '0; st = '0; d = '0; at = -1;
    for (int i = 0; i < budget && v == '0; i++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        v = resp_valid; st = resp_status; d = resp_data; at = cyc;
      end
    end
    if (v != '0) begin
      @(posedge clk);
      #1;
      req = req & ~v;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; prov_req = 1'b0; fuse_req = 1'b0; req = '0; force_fire = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_state",  state_out, 3'd0);
    check("rst_time",   reg_time, 8'd0);
    check("rst_resp",   {resp_valid, resp_status, resp_data}, '0);
    check("rst_regout", {reg_init, reg_read, reg_fuse_blow, reg_basis, reg_phase, reg_identity}, '0);
    check("rst_tamper", tamper_flag, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [N-1:0] v;
  logic [1:0]   st;
  logic [7:0]   d;
  int at, at1, t0, i0, r0, b0;

  initial begin
    // OK read by requester 1 at time >= 50
    do_reset();
    i0 = n_init;
    tick(1);
    provision();
    check("prov_state", state_out, 3'd1);
    wait_time(50);
    set_meta(1, 2'b01, 2'b10, 4'hA);
    r0 = n_read;
    req[1] = 1'b1;
    t0 = cyc;
    wait_resp(10, v, st, d, at);
    check("ok_valid", v, 4'b0010);
    check("ok_status", st, 2'd0);
    check("ok_data", d, 8'h5C);
    check("ok_latency", at - t0, 2);
    check("ok_init_cnt", n_init - i0, 1);
    check("ok_read_cnt", n_read - r0, 1);
    check("ok_rd_id", rd_id, 4'hA);
    check("ok_rd_basis", rd_basis, 2'b01);
    check("ok_spent_state", state_out, 3'd5);

    // Spent responses in round-robin order 2,3,0
    set_meta(0, 2'b01, 2'b10, 4'hA);
    set_meta(2, 2'b01, 2'b10, 4'hA);
    set_meta(3, 2'b01, 2'b10, 4'hA);
    req = 4'b1101;
    wait_resp(5, v, st, d, at);
    check("sp1_valid", v, 4'b0100);
    check("sp1_status", {st, d}, {2'd2, 8'h00});
    at1 = at;
    wait_resp(5, v, st, d, at);
    check("sp2_valid", v, 4'b1000);
    check("sp2_status", {st, d}, {2'd2, 8'h00});
    check("sp2_consec", at - at1, 1);
    at1 = at;
    wait_resp(5, v, st, d, at);
    check("sp3_valid", v, 4'b0001);
    check("sp3_status", {st, d}, {2'd2, 8'h00});
    check("sp3_consec", at - at1, 1);
    check("sp_no_reread", n_read - r0, 1);

    // Wrong basis -> DENIED, then SPENT
    do_reset();
    tick(1);
    provision();
    wait_time(50);
    set_meta(3, 2'b11, 2'b10, 4'hA);
    r0 = n_read;
    req[3] = 1'b1;
    wait_resp(10, v, st, d, at);
    check("deny_valid", v, 4'b1000);
    check("deny_status", {st, d}, {2'd1, 8'h00});
    set_meta(0, 2'b01, 2'b10, 4'hA);
    req[0] = 1'b1;
    wait_resp(10, v, st, d, at);
    check("deny_next_valid", v, 4'b0001);
    check("deny_next_status", {st, d}, {2'd2, 8'h00});
    check("deny_read_cnt", n_read - r0, 1);

    // Read before the validity window, then time saturation
    do_reset();
    set_meta(0, 2'b01, 2'b10, 4'hA);
    prov_req = 1'b1;
    req[0] = 1'b1;
    tick(1);
    prov_req = 1'b0;
    wait_resp(10, v, st, d, at);
    check("early_valid", v, 4'b0001);
    check("early_status", {st, d}, {2'd1, 8'h00});
    check("early_rd_time", rd_time, 8'd3);
    tick(300);
    check("time_sat", reg_time, 8'd255);
    tick(1);
    check("time_hold", reg_time, 8'd255);

    // fuse_req together with a request in ARMED
    do_reset();
    tick(1);
    provision();
    wait_state(3'd2);
    r0 = n_read;
    b0 = n_blow;
    set_meta(2, 2'b01, 2'b10, 4'hA);
    req[2] = 1'b1;
    fuse_req = 1'b1;
    tick(1);
    fuse_req = 1'b0;
    check("fuse_blow", reg_fuse_blow, 1'b1);
    check("fuse_state", state_out, 3'd6);
    wait_resp(10, v, st, d, at);
    check("fuse_valid", v, 4'b0100);
    check("fuse_status", {st, d}, {2'd3, 8'h00});
    check("fuse_no_read", n_read - r0, 0);
    check("fuse_blow_cnt", n_blow - b0, 1);
    provision();
    tick(2);
    check("fuse_prov_ignored", state_out, 3'd6);
    check("fuse_no_tamper", tamper_flag, 1'b0);

    // Spurious fuse_fire in ARMED
    do_reset();
    tick(1);
    provision();
    wait_state(3'd2);
    force_fire = 1'b1;
    tick(1);
    force_fire = 1'b0;
    check("tamper_flag", tamper_flag, 1'b1);
    check("tamper_state", state_out, 3'd6);
    tick(3);
    check("tamper_sticky", tamper_flag, 1'b1);

`ifdef QKD_ARB_ID_FILTER_EN
    // Identity pre-filter
    do_reset();
    tick(1);
    provision();
    wait_time(50);
    r0 = n_read;
    set_meta(1, 2'b01, 2'b10, 4'h3);
    req[1] = 1'b1;
    t0 = cyc;
    wait_resp(10, v, st, d, at);
    check("filt_valid", v, 4'b0010);
    check("filt_status", {st, d}, {2'd1, 8'h00});
    check("filt_latency", at - t0, 1);
    check("filt_no_read", n_read - r0, 0);
    check("filt_armed", state_out, 3'd2);
    set_meta(2, 2'b01, 2'b10, 4'hA);
    req[2] = 1'b1;
    wait_resp(10, v, st, d, at);
    check("filt_ok_valid", v, 4'b0100);
    check("filt_ok_status", {st, d}, {2'd0, 8'h5C});
    check("filt_read_cnt", n_read - r0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
